vga_pattern_writer: RTL

//  Framebuffer pattern writer for the VGA subsystem. Sweeps the whole 1-bit framebuffer through its write port.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_pattern_writer_if.sv | 11 +
 rtl/vga_tick_gen.sv | 27 ++
 rtl/vga_pattern_writer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer pattern writer.
package vga_pkg;

    localparam int COLOUR_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_CHEQUER = 2'd0,
        MODE_VSTRIPE = 2'd1,
        MODE_HSTRIPE = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_FILL  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    // Pixel value for a mode, given the tile-select bits of the column and row.
    function automatic logic pattern_bit(input mode_e mode, input logic xs_bit, input logic y_bit);
        logic pix;
        pix = 1'b1;
        case (mode)
            MODE_CHEQUER: pix = xs_bit ^ y_bit;
            MODE_VSTRIPE: pix = xs_bit;
            MODE_HSTRIPE: pix = y_bit;
            default:      pix = 1'b1;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/vga_pattern_writer_if.sv
// Framebuffer write port: the pattern writer is the master, the framebuffer the slave.
interface vga_pattern_writer_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0] FB_ADDR;
    logic                  FB_DATA;
    logic                  FB_WE;

    modport master (output FB_ADDR, output FB_DATA, output FB_WE);
    modport slave  (input  FB_ADDR, input  FB_DATA, input  FB_WE);
endinterface

// File: rtl/vga_tick_gen.sv
// Free-running period counter; TICK_OUT pulses for one cycle each time it wraps.
module vga_tick_gen #(
    parameter int TICK_WIDTH = 26,
    parameter int TICK_MAX   = 50_000_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK_OUT
);
    localparam logic [TICK_WIDTH-1:0] CNT_LAST = TICK_WIDTH'(TICK_MAX - 1);

    logic [TICK_WIDTH-1:0] cnt;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt      <= '0;
            TICK_OUT <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            TICK_OUT <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            TICK_OUT <= 1'b0;
        end
    end
endmodule

// File: rtl/vga_pattern_writer.sv
// Sweeps the 1-bit framebuffer with a selectable pattern once per period tick.
// Define VGA_PATTERN_SCROLL_EN to make the stripe/chequer patterns scroll one pixel per refill.
module vga_pattern_writer
    import vga_pkg::*;
#(
    parameter int H_PIXELS   = 160,
    parameter int V_PIXELS   = 120,
    parameter int ADDR_WIDTH = 15,
    parameter int TILE_LOG2  = 3,
    parameter int TICK_WIDTH = 26,
    parameter int TICK_MAX   = 50_000_000
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ENABLE_IN,
    input  logic [1:0]                   MODE_IN,
    vga_pattern_writer_if.master         fb,
    output logic [2*COLOUR_WIDTH-1:0]    COLOURS_OUT,
    output logic                         BUSY_OUT,
    output logic                         FRAME_DONE
);
    localparam int X_W = $clog2(H_PIXELS);
    localparam int Y_W = $clog2(V_PIXELS);
    localparam int S_W = TILE_LOG2 + 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

    state_e                  state;
    mode_e                   mode_q;
    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [COLOUR_WIDTH-1:0] colour_cnt;
    logic                    tick;
    logic [S_W-1:0]          scroll_use;
    logic                    xs_bit;
    logic                    pix;

    vga_tick_gen #(
        .TICK_WIDTH (TICK_WIDTH),
        .TICK_MAX   (TICK_MAX)
    ) u_tick (
        .CLK      (CLK),
        .RESET    (RESET),
        .TICK_OUT (tick)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) colour_cnt <= '0;
        else if (tick) colour_cnt <= colour_cnt + 1'b1;
    end

    assign COLOURS_OUT = {colour_cnt, {COLOUR_WIDTH{1'b1}}};

`ifdef VGA_PATTERN_SCROLL_EN
    logic [S_W-1:0] scroll_q;

    // The frame being latched uses the count from before this LATCH, so the first frame is unscrolled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scroll_q   <= '0;
            scroll_use <= '0;
        end else if (state == ST_LATCH) begin
            scroll_q   <= scroll_q + 1'b1;
            scroll_use <= scroll_q;
        end
    end
`else
    assign scroll_use = '0;
`endif

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        xs_bit = 1'((x[S_W-1:0] + scroll_use) >> TILE_LOG2);
        pix    = pattern_bit(mode_q, xs_bit, y[TILE_LOG2]);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_CHEQUER;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            fb.FB_ADDR <= '0;
            fb.FB_DATA <= 1'b0;
            fb.FB_WE   <= 1'b0;
            BUSY_OUT   <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            fb.FB_WE   <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ENABLE_IN) begin
                        state    <= ST_LATCH;
                        BUSY_OUT <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    mode_q   <= mode_e'(MODE_IN);
                    x        <= '0;
                    y        <= '0;
                    addr     <= '0;
                    state    <= ST_FILL;
                    BUSY_OUT <= 1'b1;
                end
                ST_FILL: begin
                    fb.FB_WE   <= 1'b1;
                    fb.FB_ADDR <= addr;
                    fb.FB_DATA <= pix;
                    addr       <= addr + 1'b1;
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            state      <= ST_WAIT;
                            BUSY_OUT   <= 1'b0;
                            FRAME_DONE <= 1'b1;
                        end else begin
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Ticks seen during FILL are dropped; only a tick here restarts.
                    if (tick) begin
                        state    <= ENABLE_IN ? ST_LATCH : ST_IDLE;
                        BUSY_OUT <= ENABLE_IN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
